// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the multi-stage ALU sequencer: state encoding,
// instruction classes and instruction-register field positions.
package alu_ctrl_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_RSEL_W = 2;
    localparam int DEF_FN_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [1:0] CLS_LOAD = 2'b00;
    localparam logic [1:0] CLS_COPY = 2'b01;
    localparam logic [1:0] CLS_ALU2 = 2'b10;
    localparam logic [1:0] CLS_ALU1 = 2'b11;

    // Least significant bit of each instruction-register field
    localparam int IR_CLS_LO = 8;
    localparam int IR_RX_LO  = 6;
    localparam int IR_RY_LO  = 4;
    localparam int IR_FN_LO  = 0;

    function automatic logic is_short(input logic [1:0] cls);
        return (cls == CLS_LOAD) || (cls == CLS_COPY);
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational instruction-register field decoder: class, register selects,
// one-hot destination and ALU function code.
module alu_ctrl_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RSEL_W = DEF_RSEL_W,
    parameter int FN_W   = DEF_FN_W
) (
    input  logic [DATA_W-1:0]        ir,
    output logic [1:0]               cls,
    output logic [RSEL_W-1:0]        rx,
    output logic [RSEL_W-1:0]        ry,
    output logic [(1<<RSEL_W)-1:0]   rx_oh,
    output logic [FN_W-1:0]          fn
);

    assign cls = ir[IR_CLS_LO +: 2];
    assign rx  = ir[IR_RX_LO +: RSEL_W];
    assign ry  = ir[IR_RY_LO +: RSEL_W];
    assign fn  = ir[IR_FN_LO +: FN_W];

    always_comb begin
        rx_oh     = '0;
        rx_oh[rx] = 1'b1;
    end

endmodule

// File: rtl/multi_stage_alu_ctrl.sv
// Sequencing FSM for the multi-stage ALU: latches an instruction and steps the
// register file, bus and ALU controls. Define ALU_CTRL_PERF_EN to add the
// 16-bit saturating retired-instruction counter output.
//
//   state | meaning
//   IDLE  | waiting for exec, all controls low
//   T1    | first execution cycle (final for LOAD/COPY)
//   T2    | ALU operand B cycle, G loads result
//   T3    | ALU write-back from G, final cycle
module multi_stage_alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RSEL_W = DEF_RSEL_W,
    parameter int FN_W   = DEF_FN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exec,
    input  logic [DATA_W-1:0]         instr,
    output logic                      ir_ld,
    output logic                      rf_out_en,
    output logic [RSEL_W-1:0]         rf_out_sel,
    output logic [(1<<RSEL_W)-1:0]    rf_wr_en,
    output logic                      ext_out,
    output logic                      Ain,
    output logic                      Gin,
    output logic                      Gout,
    output logic [FN_W-1:0]           FN,
    output logic                      busy,
    output logic                      done
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]               retired
`endif
);

    state_t                   state, state_nxt;
    logic [DATA_W-1:0]        ir;
    logic [1:0]               cls;
    logic [RSEL_W-1:0]        rx, ry;
    logic [(1<<RSEL_W)-1:0]   rx_oh;
    logic [FN_W-1:0]          fn;

    alu_ctrl_decoder #(
        .DATA_W (DATA_W),
        .RSEL_W (RSEL_W),
        .FN_W   (FN_W)
    ) u_dec (
        .ir    (ir),
        .cls   (cls),
        .rx    (rx),
        .ry    (ry),
        .rx_oh (rx_oh),
        .fn    (fn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (ir_ld)
                ir <= instr;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = exec ? T1 : IDLE;
            T1:      state_nxt = is_short(cls) ? (exec ? T1 : IDLE) : T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = exec ? T1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rf_out_en  = 1'b0;
        rf_out_sel = '0;
        rf_wr_en   = '0;
        ext_out    = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        FN         = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        unique case (state)
            IDLE: ;
            T1: begin
                if (cls == CLS_LOAD) begin
                    ext_out  = 1'b1;
                    rf_wr_en = rx_oh;
                    done     = 1'b1;
                end else if (cls == CLS_COPY) begin
                    rf_out_en  = 1'b1;
                    rf_out_sel = ry;
                    rf_wr_en   = rx_oh;
                    done       = 1'b1;
                end else begin
                    rf_out_en  = 1'b1;
                    rf_out_sel = rx;
                    Ain        = 1'b1;
                end
            end
            T2: begin
                // Single-operand ops re-drive Rx so the bus never floats
                rf_out_en  = 1'b1;
                rf_out_sel = (cls == CLS_ALU1) ? rx : ry;
                Gin        = 1'b1;
                FN         = fn;
            end
            T3: begin
                Gout     = 1'b1;
                rf_wr_en = rx_oh;
                done     = 1'b1;
            end
            default: ;
        endcase
        ir_ld = exec && ((state == IDLE) || done);
    end

`ifdef ALU_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired <= '0;
        else if (done && (retired != 16'hFFFF))
            retired <= retired + 16'd1;
    end
`endif

endmodule

// File: doc/multi_stage_alu_ctrl.md
Name: multi_stage_alu_ctrl

Overview:
- Sequencing FSM for the multi-stage ALU in the 10-bit processor.
- Latches a 10-bit instruction word, decodes it, and steps the register file, the shared data bus and the ALU controls (Ain, Gin, Gout, FN) through the one-to-three execution cycles each instruction needs.
- Sits between the instruction source and the datapath. Its outputs connect directly to the ALU and register-file enables.

Parameters:
- DATA_W, 10, instruction/data word width.
- RSEL_W, 2, register select field width (4 registers).
- FN_W, 4, ALU function code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- exec  in  1  start request; sampled only when accepting (IDLE or final T state).
- instr  in  DATA_W  instruction word; latched into IR when exec is accepted.
- ir_ld  out  1  high in the cycle an instruction is accepted.
- rf_out_en  out  1  selected register drives bus.
- rf_out_sel  out  RSEL_W  register driving bus.
- rf_wr_en  out  4  one-hot register write enable (bus -> Rx).
- ext_out  out  1  external data drives bus (load).
- Ain  out  1  ALU A-register load.
- Gin  out  1  ALU G-register load.
- Gout  out  1  G drives bus.
- FN  out  FN_W  ALU function code, valid when Gin=1, else 0.
- busy  out  1  high in T1..T3.
- done  out  1  high for exactly the final execution cycle of each instruction.

Behaviour:
- IR fields:
  - IR[9:8] = class: 00 LOAD, 01 COPY, 10 ALU2, 11 ALU1.
  - IR[7:6] = Rx (destination and first operand).
  - IR[5:4] = Ry (second operand / source).
  - IR[3:0] = FN.
- States: IDLE, T1, T2, T3. Outputs are Moore, decoded from state plus IR.
- IDLE:
  - All outputs 0.
  - exec=1: ir_ld=1, IR<=instr, next T1.
- LOAD (1 cycle): T1 drives ext_out=1, rf_wr_en[Rx]=1, done=1.
- COPY (1 cycle): T1 drives rf_out_en=1, rf_out_sel=Ry, rf_wr_en[Rx]=1, done=1.
- ALU2 (3 cycles):
  - T1: rf_out_en=1, rf_out_sel=Rx, Ain=1.
  - T2: rf_out_en=1, rf_out_sel=Ry, Gin=1, FN=IR[3:0].
  - T3: Gout=1, rf_wr_en[Rx]=1, done=1.
- ALU1 (3 cycles): same as ALU2, except T2 drives rf_out_sel=Rx so the bus is deterministic.
- Final state (done=1):
  - exec=1: ir_ld=1, IR<=instr, next T1. Back-to-back execution with no IDLE bubble.
  - exec=0: next IDLE.
- exec in non-final T states is ignored and the instruction is dropped. The requester must hold exec until it sees ir_ld.
- Bus exclusivity invariant: at most one of rf_out_en, ext_out, Gout is high in any cycle.
- rf_wr_en is one-hot or zero, never multi-hot.
- Reset, including mid-instruction: state=IDLE, IR=0, all outputs 0 immediately. The partial instruction is abandoned with no write.
- Latency from exec accept to done: LOAD/COPY 1 cycle, ALU1/ALU2 3 cycles.

Optional Feature:
- Macro ALU_CTRL_PERF_EN.
- Defined: adds output port retired, width 16. It counts cycles with done=1, saturates at 16'hFFFF, and resets to 0.
- Undefined: no port, no counter logic. FSM timing is identical either way.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the state enum (IDLE, T1, T2, T3);
  - the class localparams (CLS_LOAD, CLS_COPY, CLS_ALU2, CLS_ALU1);
  - IR field position constants;
  - DATA_W/RSEL_W/FN_W defaults.
- One sub-module: alu_ctrl_decoder. It is combinational, takes IR, and returns class, Rx, Ry, one-hot Rx and FN. The FSM lives in the top.

Test Plan:
- Reset, then exec=1 with instr=0x080 (LOAD R2) -> next cycle ext_out=1, rf_wr_en=4'b0100, done=1; the following cycle is IDLE with all outputs 0.
- instr=0x130 (COPY R0<-R3) -> T1: rf_out_en=1, rf_out_sel=3, rf_wr_en=4'b0001, done=1.
- instr=0x271 (ALU2 R1<-R1 FN R3, FN=1):
  - T1: sel=1, Ain=1.
  - T2: sel=3, Gin=1, FN=4'h1.
  - T3: Gout=1, rf_wr_en=4'b0010, done=1.
  - Check ALU1 instr=0x3C5 the same way: T2 sel=3, FN=4'h5.
- ALU2 0x271 with exec held high and instr changed to 0x080 at T3:
  - T3 shows ir_ld=1.
  - Next cycle is LOAD T1 with no IDLE cycle.
  - exec pulses during T1/T2 are ignored.
- Assert rst during T2 of 0x271 -> all outputs 0 in the same cycle, no rf_wr_en pulse, IDLE after release.
- Random instruction stream with an invariant checker: at most one bus driver per cycle, one-hot rf_wr_en. With ALU_CTRL_PERF_EN defined, retired equals the count of done pulses.
